// File: rtl/regfile_pkg.sv
// Shared constants and types for the LUMOS scoreboarded register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_DEPTH      = 5;
  localparam int DEFAULT_READ_PORTS = 2;
  localparam int REG_COUNT          = 2 ** DEFAULT_DEPTH;

  typedef logic [DEFAULT_DEPTH-1:0] reg_index_t;
  typedef logic [DEFAULT_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: decode reserves a destination, writeback releases it.
// Register 0 is masked out when it is hardwired to zero.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reserve_enable,
  input  logic [DEPTH-1:0]    reserve_index,
  input  logic                write_enable,
  input  logic [DEPTH-1:0]    write_index,
  output logic [2**DEPTH-1:0] busy,
  output logic                reserve_conflict
);

  localparam int NUM_REGS = 2 ** DEPTH;
  localparam bit ZERO_EN  = (ZERO_REG != 0);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic                conflict_r;
  logic                conflict_s;
  logic                reserve_ok_s;
  logic                release_ok_s;

  assign reserve_ok_s = reserve_enable && !(ZERO_EN && (reserve_index == {DEPTH{1'b0}}));
  assign release_ok_s = write_enable && !(ZERO_EN && (write_index == {DEPTH{1'b0}}));

  // Release first, then reserve, so a same-edge write+reserve leaves the register busy.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_next_s[i] = (busy_r[i] && !(release_ok_s && (write_index == DEPTH'(i))))
                     || (reserve_ok_s && (reserve_index == DEPTH'(i)));
    end
    conflict_s = reserve_ok_s && busy_r[reserve_index]
               && !(release_ok_s && (write_index == reserve_index));
  end

  // Scoreboard state and registered conflict pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= {NUM_REGS{1'b0}};
      conflict_r <= 1'b0;
    end else begin
      busy_r     <= busy_next_s;
      conflict_r <= conflict_s;
    end
  end

  assign busy             = busy_r;
  assign reserve_conflict = conflict_r;

endmodule

// File: rtl/register_file_sb.sv
// LUMOS register file: READ_PORTS registered read ports, one write port, integrated scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write data to reads.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int READ_PORTS = DEFAULT_READ_PORTS,
  parameter int ZERO_REG   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [READ_PORTS-1:0]       read_enable,
  input  logic [READ_PORTS*DEPTH-1:0] read_index,
  output logic [READ_PORTS*WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]       read_valid,
  input  logic                        reserve_enable,
  input  logic [DEPTH-1:0]            reserve_index,
  output logic                        reserve_conflict,
  input  logic                        write_enable,
  input  logic [DEPTH-1:0]            write_index,
  input  logic [WIDTH-1:0]            write_data,
  output logic [2**DEPTH-1:0]         busy
);

  localparam int NUM_REGS = 2 ** DEPTH;
  localparam bit ZERO_EN  = (ZERO_REG != 0);

  logic [WIDTH-1:0]            regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]         busy_s;
  logic                        write_ok_s;
  logic [DEPTH-1:0]            port_idx_s   [READ_PORTS];
  logic [READ_PORTS-1:0]       zero_hit_s;
  logic [READ_PORTS-1:0]       bypass_hit_s;
  logic [READ_PORTS*WIDTH-1:0] data_next_s;
  logic [READ_PORTS-1:0]       valid_next_s;
  logic [READ_PORTS*WIDTH-1:0] read_data_r;
  logic [READ_PORTS-1:0]       read_valid_r;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk              (clk),
    .reset            (reset),
    .reserve_enable   (reserve_enable),
    .reserve_index    (reserve_index),
    .write_enable     (write_enable),
    .write_index      (write_index),
    .busy             (busy_s),
    .reserve_conflict (reserve_conflict)
  );

  assign write_ok_s = write_enable && !(ZERO_EN && (write_index == {DEPTH{1'b0}}));

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    assign port_idx_s[p] = read_index[p*DEPTH +: DEPTH];
    assign zero_hit_s[p] = ZERO_EN && (port_idx_s[p] == {DEPTH{1'b0}});
`ifdef REGFILE_BYPASS_EN
    assign bypass_hit_s[p] = write_enable && (write_index == port_idx_s[p]) && !zero_hit_s[p];
`else
    assign bypass_hit_s[p] = 1'b0;
`endif
  end

  // Per-port read decision; busy is the pre-edge scoreboard state.
  always_comb begin
    data_next_s  = {(READ_PORTS*WIDTH){1'b0}};
    valid_next_s = {READ_PORTS{1'b0}};
    for (int p = 0; p < READ_PORTS; p++) begin
      if (!read_enable[p]) begin
        valid_next_s[p] = 1'b0;
      end else if (zero_hit_s[p]) begin
        valid_next_s[p] = 1'b1;
      end else if (bypass_hit_s[p]) begin
        data_next_s[p*WIDTH +: WIDTH] = write_data;
        valid_next_s[p]               = 1'b1;
      end else if (busy_s[port_idx_s[p]]) begin
        valid_next_s[p] = 1'b0;
      end else begin
        data_next_s[p*WIDTH +: WIDTH] = regs_r[port_idx_s[p]];
        valid_next_s[p]               = 1'b1;
      end
    end
  end

  // Storage array and registered read ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
      read_data_r  <= {(READ_PORTS*WIDTH){1'b0}};
      read_valid_r <= {READ_PORTS{1'b0}};
    end else begin
      if (write_ok_s) begin
        regs_r[write_index] <= write_data;
      end
      read_data_r  <= data_next_s;
      read_valid_r <= valid_next_s;
    end
  end

  assign read_data  = read_data_r;
  assign read_valid = read_valid_r;
  assign busy       = busy_s;

endmodule
